// File: rtl/btpipe_pkg.sv
// Shared types and defaults for the block-throttled pipe-out data source.
package btpipe_pkg;

  localparam int WORD_W              = 16;
  localparam int DEFAULT_DEPTH_LOG2  = 10;
  localparam int DEFAULT_BLOCK_WORDS = 256;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t PATTERN_START = 16'h0000;

  // Next value of the internal counter source; wraps naturally at 0xFFFF.
  function automatic word_t nextPattern(input word_t cur);
    return cur + word_t'(1);
  endfunction

endpackage

// File: rtl/btpipe_fifo_ram.sv
// Simple dual-port FIFO storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module btpipe_fifo_ram
  import btpipe_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_DEPTH_LOG2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  word_t             wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output word_t             rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Write port: contents are left uninitialised so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port: holds the last word unless a new read is enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/btpipe_block_source.sv
// Block-throttled pipe-out source: buffers external samples or an internal
// counter pattern and signals ready once a whole host block is available.
module btpipe_block_source
  import btpipe_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
  input  logic                ti_clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                pattern_mode,
  input  logic [WORD_W-1:0]   din,
  input  logic                din_valid,
  input  logic                ep_read,
  input  logic                ep_blockstrobe,
  output logic [WORD_W-1:0]   ep_datain,
  output logic                ep_ready,
  output logic [DEPTH_LOG2:0] fill_count,
  output logic                overflow,
  output logic                underflow,
  output logic [15:0]         blocks_started
);

  localparam int                  PTR_W     = DEPTH_LOG2;
  localparam int                  CNT_W     = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(2 ** DEPTH_LOG2);
  localparam logic [CNT_W-1:0]    BLOCK_CNT = CNT_W'(BLOCK_WORDS);

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [15:0]      blocks_q, blocks_d;
  word_t            pattern_q, pattern_d;

  logic  writeReq;
  logic  isFull;
  logic  isEmpty;
  logic  wrAccept;
  logic  rdAccept;
  word_t wrData;

  // Next-state logic: clear wins over everything, full drops writes, empty drops pops.
  always_comb begin
    writeReq = pattern_mode ? 1'b1 : din_valid;
    isFull   = (fill_q == DEPTH_CNT);
    isEmpty  = (fill_q == '0);
    wrAccept = writeReq & ~isFull & ~clear;
    rdAccept = ep_read & ~isEmpty & ~clear;
    wrData   = pattern_mode ? pattern_q : din;

    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fill_d      = fill_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    blocks_d    = blocks_q;
    pattern_d   = pattern_q;

    if (clear) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      fill_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      blocks_d    = '0;
      pattern_d   = PATTERN_START;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
        if (pattern_mode) begin
          pattern_d = nextPattern(pattern_q);
        end
      end
      if (rdAccept) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({wrAccept, rdAccept})
        2'b10:   fill_d = fill_q + CNT_W'(1);
        2'b01:   fill_d = fill_q - CNT_W'(1);
        default: fill_d = fill_q;
      endcase
      if (writeReq && isFull) begin
        overflow_d = 1'b1;
      end
      if (ep_read && isEmpty) begin
        underflow_d = 1'b1;
      end
      if (ep_blockstrobe) begin
        blocks_d = blocks_q + 16'd1;
      end
    end
  end

  // State registers, cleared asynchronously so buffered data is discarded on reset.
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      blocks_q    <= '0;
      pattern_q   <= PATTERN_START;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      blocks_q    <= blocks_d;
      pattern_q   <= pattern_d;
    end
  end

  btpipe_fifo_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (ti_clk),
    .rst_i   (reset),
    .we_i    (wrAccept),
    .waddr_i (wrPtr_q),
    .wdata_i (wrData),
    .re_i    (rdAccept),
    .raddr_i (rdPtr_q),
    .rdata_o (ep_datain)
  );

  assign ep_ready       = (fill_q >= BLOCK_CNT);
  assign fill_count     = fill_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign blocks_started = blocks_q;

endmodule
